// File: rtl/vga_tile_pkg.sv
// Shared types and constants for the tile framebuffer: colour layout,
// UART load sync byte and load FSM states.
package vga_tile_pkg;

  localparam int COLOUR_W = 12;
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } load_state_t;

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile RAM: one write port and one registered read port.
// A read and write to the same address in one cycle return the old word.
module tile_ram #(
  parameter int DEPTH  = 300,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Contents come up black at configuration and are never touched by reset.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_framebuffer.sv
// Writable COLS x ROWS tile framebuffer between the VGA timing generator and
// the DAC, loaded from a UART byte stream. Optional `TILE_FRAMEBUFFER_DOUBLE_BUFFER_EN.
module tile_framebuffer
  import vga_tile_pkg::*;
#(
  parameter int TILE_SHIFT = 5,
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int CNT_W      = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    h_count,
  input  logic [CNT_W-1:0]    v_count,
  input  logic                video_on,
  output logic [COLOUR_W-1:0] rgb_colour,
  input  logic                wr_valid,
  input  logic [7:0]          wr_data,
  output logic                wr_ready,
  output logic                load_done
);

  localparam int NTILES = COLS * ROWS;
  localparam int ADDR_W = $clog2(NTILES);
  localparam int IDX_W  = CNT_W - TILE_SHIFT;

  function automatic logic [ADDR_W-1:0] tile_index(input logic [IDX_W-1:0] col,
                                                   input logic [IDX_W-1:0] row);
    return ADDR_W'(32'(row) * 32'(COLS) + 32'(col));
  endfunction

  logic [IDX_W-1:0]    col_in, row_in;
  logic                in_range_in;
  logic [IDX_W-1:0]    col_p1, row_p1;
  logic                in_range_p1, vld_p1;
  logic                in_range_p2, vld_p2;
  logic [ADDR_W-1:0]   raddr;
  logic [COLOUR_W-1:0] rdata_p2;
  logic                unused_lsbs;

  assign col_in      = h_count[CNT_W-1:TILE_SHIFT];
  assign row_in      = v_count[CNT_W-1:TILE_SHIFT];
  assign in_range_in = (32'(col_in) < 32'(COLS)) && (32'(row_in) < 32'(ROWS));
  assign unused_lsbs = ^{h_count[TILE_SHIFT-1:0], v_count[TILE_SHIFT-1:0]};

  // Stage 1: tile coordinates and qualifiers
  always_ff @(posedge clk) begin
    col_p1 <= col_in;
    row_p1 <= row_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      in_range_p1 <= 1'b0;
      vld_p2      <= 1'b0;
      in_range_p2 <= 1'b0;
    end else begin
      vld_p1      <= video_on;
      in_range_p1 <= in_range_in;
      vld_p2      <= vld_p1;
      in_range_p2 <= in_range_p1;
    end
  end

  // Stage 2: RAM read; off-grid coordinates are parked on tile 0
  assign raddr      = in_range_p1 ? tile_index(col_p1, row_p1) : '0;
  assign rgb_colour = (vld_p2 && in_range_p2) ? rdata_p2 : '0;

  load_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic [3:0]        r_lat;
  logic              ready_q;
  logic              accept;
  logic              we;
  logic              last_tile;
  rgb_t              wr_colour;

  assign wr_ready  = ready_q & rst_n;
  assign accept    = wr_valid && wr_ready;
  assign we        = accept && (state == LO);
  assign last_tile = (ptr == ADDR_W'(NTILES - 1));
  assign wr_colour = '{r: r_lat, g: wr_data[7:4], b: wr_data[3:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      ready_q   <= 1'b0;
      load_done <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      load_done <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (wr_data == SYNC_BYTE) begin
              state <= HI;
              ptr   <= '0;
            end
          end
          HI: state <= LO;
          LO: begin
            if (last_tile) begin
              load_done <= 1'b1;
              ptr       <= '0;
              state     <= IDLE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= HI;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Red nibble waits here for the {G,B} byte; only the low nibble is meaningful.
  always_ff @(posedge clk) begin
    if (accept && state == HI) r_lat <= wr_data[3:0];
  end

`ifdef TILE_FRAMEBUFFER_DOUBLE_BUFFER_EN
  logic                front, swap_pending, front_p2;
  logic                frame_start;
  logic [COLOUR_W-1:0] rdata0, rdata1;

  assign frame_start = (h_count == '0) && (v_count == '0);

  // The loader always fills the bank that is not on screen.
  tile_ram #(.DEPTH(NTILES), .WIDTH(COLOUR_W)) u_bank0 (
    .clk(clk), .we(we && front), .waddr(ptr), .wdata(wr_colour),
    .raddr(raddr), .rdata(rdata0)
  );

  tile_ram #(.DEPTH(NTILES), .WIDTH(COLOUR_W)) u_bank1 (
    .clk(clk), .we(we && !front), .waddr(ptr), .wdata(wr_colour),
    .raddr(raddr), .rdata(rdata1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      front_p2     <= 1'b0;
    end else begin
      front_p2 <= front;
      if (frame_start && swap_pending) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (load_done) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign rdata_p2 = front_p2 ? rdata1 : rdata0;
`else
  tile_ram #(.DEPTH(NTILES), .WIDTH(COLOUR_W)) u_bank0 (
    .clk(clk), .we(we), .waddr(ptr), .wdata(wr_colour),
    .raddr(raddr), .rdata(rdata_p2)
  );
`endif

endmodule

// File: tb/tb_tile_framebuffer.sv
// Randomised bench for tile_framebuffer against a tile-array reference model;
// follows `TILE_FRAMEBUFFER_DOUBLE_BUFFER_EN when it is defined.
module tb_tile_framebuffer;

  localparam int NT = 300;
`ifdef TILE_FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_count, v_count;
  logic        video_on;
  logic [11:0] rgb_colour;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        load_done;

  always #5 clk = ~clk;

  tile_framebuffer #(.TILE_SHIFT(5), .COLS(20), .ROWS(15), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .video_on(video_on), .rgb_colour(rgb_colour), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .load_done(load_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two tile images, which one is on screen, and the
  // position within the current load (-1 = hunting for the sync byte).
  logic [11:0] bank [2][NT];
  logic [11:0] img [NT];
  int          m_front, m_pos, m_loads;
  logic [3:0]  m_r;
  bit          m_ld, m_pend;
  int          ld_cnt = 0;

  typedef struct {
    int h;
    int v;
    bit vid;
  } pix_t;
  pix_t pq[$];

  always @(negedge clk) if (load_done === 1'b1) ld_cnt++;

  function automatic logic [11:0] exp_pix(input pix_t p);
    int col, row;
    col = p.h / 32;
    row = p.v / 32;
    if (p.vid && col < 20 && row < 15) return bank[m_front][row * 20 + col];
    return 12'h000;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int wb;
    wb = DB ? 1 - m_front : 0;
    if (m_pos < 0) begin
      if (b == 8'h55) m_pos = 0;
    end else if (m_pos % 2 == 0) begin
      m_r = b[3:0];
      m_pos++;
    end else begin
      bank[wb][m_pos / 2] = {m_r, b};
      if (m_pos / 2 == NT - 1) begin
        m_pos = -1;
        m_ld = 1'b1;
        m_loads++;
      end else begin
        m_pos++;
      end
    end
  endtask

  // One clock: advance the model by what the DUT samples at this edge.
  task automatic step();
    bit acc, ld_now;
    acc = wr_valid && wr_ready && rst_n;
    ld_now = m_ld;
    m_ld = 1'b0;
    if (!rst_n) begin
      m_pos = -1;
      m_front = 0;
      m_pend = 1'b0;
    end else begin
      if (acc) model_byte(wr_data);
      if (DB && h_count == 10'd0 && v_count == 10'd0 && m_pend) begin
        m_front = 1 - m_front;
        m_pend = 1'b0;
      end else if (ld_now) begin
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int h, input int v, input bit vid);
    pix_t p;
    h_count = 10'(h);
    v_count = 10'(v);
    video_on = vid;
    p.h = h;
    p.v = v;
    p.vid = vid;
    pq.push_back(p);
    step();
    if (pq.size() >= 2) begin
      p = pq.pop_front();
      check($sformatf("rgb h=%0d v=%0d vid=%0d", p.h, p.v, p.vid),
            32'(rgb_colour), 32'(exp_pix(p)));
    end
  endtask

  task automatic rand_disp(input int n);
    pq.delete();
    repeat (n) disp($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit was, done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_data = b;
    for (int i = 0; i < 8 && !done; i++) begin
      was = wr_ready;
      step();
      if (was) done = 1'b1;
    end
    if (!done) check("wr_accept_timeout", 32'd0, 32'd1);
    check("load_done", 32'(load_done), 32'(m_ld));
    if ($urandom_range(0, 3) == 0) begin
      wr_valid = 1'b0;
      wr_data = 8'($urandom);
      step();
    end
  endtask

  task automatic load_img();
    send_byte(8'h55);
    for (int t = 0; t < NT; t++) begin
      if (img[t][11:8] == 4'h5) send_byte(8'h55);
      else send_byte({4'($urandom), img[t][11:8]});
      send_byte(img[t][7:0]);
    end
    wr_valid = 1'b0;
    step();
    check("load_count", 32'(ld_cnt), 32'(m_loads));
  endtask

  task automatic rand_img();
    for (int t = 0; t < NT; t++) img[t] = 12'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    h_count = '0;
    v_count = '0;
    video_on = 1'b0;
    m_front = 0;
    m_pos = -1;
    m_loads = 0;
    m_r = 4'h0;
    m_ld = 1'b0;
    m_pend = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < NT; t++) bank[b][t] = 12'h000;

    repeat (3) step();
    check("rst_rgb", 32'(rgb_colour), 32'h000);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("wr_ready_after_release", 32'(wr_ready), 32'd1);

    // Blank RAM reads as black
    pq.delete();
    repeat (6) disp(0, 0, 1'b1);

    // Garbage before sync, then tile0=F00, tile5=555 (0x55 as data), tile19=0FF
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    for (int t = 0; t < NT; t++) img[t] = 12'h000;
    img[0] = 12'hF00;
    img[5] = 12'h555;
    img[19] = 12'h0FF;
    load_img();

    pq.delete();
    repeat (3) disp(0, 0, 1'b1);
    disp(31, 31, 1'b1);
    disp(32, 0, 1'b1);
    disp(160, 0, 1'b1);
    for (int h = 600; h <= 640; h++) disp(h, 0, 1'b1);
    disp(639, 479, 1'b1);
    disp(639, 480, 1'b1);
    disp(700, 20, 1'b1);
    disp(5, 5, 1'b1);
    disp(5, 5, 1'b0);
    disp(5, 5, 1'b1);
    disp(5, 5, 1'b0);
    disp(5, 5, 1'b0);
    disp(5, 5, 1'b1);
    disp(5, 5, 1'b1);
    disp(5, 5, 1'b0);
    rand_disp(300);

    // Partial load cut short by reset, then a full load
    send_byte(8'h55);
    send_byte(8'h0A);
    send_byte(8'hBC);
    wr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid_rst_release_ready", 32'(wr_ready), 32'd1);
    pq.delete();
    repeat (3) disp(1, 1, 1'b1);
    repeat (3) disp(40, 1, 1'b1);
    rand_img();
    load_img();
    pq.delete();
    repeat (3) disp(0, 0, 1'b1);
    rand_disp(200);

    // Load completed mid-frame, then a frame start
    h_count = 10'd100;
    v_count = 10'd100;
    video_on = 1'b1;
    rand_img();
    load_img();
    pq.delete();
    repeat (4) disp(3, 3, 1'b1);
    repeat (3) disp(0, 0, 1'b1);
    repeat (4) disp(3, 3, 1'b1);
    rand_disp(100);

    step();
    check("load_done_total", 32'(ld_cnt), 32'(m_loads));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_framebuffer.md
Name: tile_framebuffer

Overview:
- Parametrised, writable successor to the fixed tile image ROM: a COLS x ROWS grid of 2^TILE_SHIFT-pixel square tiles, each holding one 12-bit RGB colour.
- Sits between the VGA timing generator (h_count/v_count/video_on) and the DAC pins.
- Loaded at runtime from the UART RX byte stream.
- Pipelined registered read path with blanking and out-of-range handling.

Parameters:
- TILE_SHIFT, 5, log2 of tile edge in pixels.
- COLS, 20, tiles per row.
- ROWS, 15, tiles per column.
- CNT_W, 10, width of h_count/v_count.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous active-low reset
- h_count  in  CNT_W  horizontal pixel counter from timing generator
- v_count  in  CNT_W  vertical line counter from timing generator
- video_on  in  1  high in the visible area
- rgb_colour  out  12  {R[3:0],G[3:0],B[3:0]} to the DAC
- wr_valid  in  1  byte available from UART RX
- wr_data  in  8  received byte
- wr_ready  out  1  byte accepted when wr_valid && wr_ready
- load_done  out  1  one-cycle pulse when the last tile of a load is written

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: rgb_colour=12'h000, load_done=0, wr_ready=0 while rst_n=0 and 1 from the first cycle after release, FSM=IDLE, tile pointer=0.
- Tile RAM is not cleared by reset. It is initialised to all 12'h000 at configuration.
- Read path, latency 2 cycles:
  - Cycle 1: register col=h_count>>TILE_SHIFT and row=v_count>>TILE_SHIFT, plus an in_range flag (col<COLS && row<ROWS), with video_on delayed 1.
  - Cycle 2: RAM read at row*COLS+col, index width $clog2(COLS*ROWS).
  - rgb_colour = RAM data if the delayed video_on && in_range, else 12'h000.
  - video_on and in_range are both delayed 2 cycles to align with the RAM data.
- Write FSM states: IDLE, HI, LO.
  - IDLE: accepted byte == SYNC_BYTE (8'h55) -> HI with pointer=0. Any other byte is discarded.
  - HI: accepted byte: low nibble is latched as R, upper nibble ignored -> LO.
  - LO: accepted byte = {G,B}. Write {R,G,B} to RAM[pointer] in the same cycle.
    - If pointer==COLS*ROWS-1: pulse load_done next cycle, pointer=0 -> IDLE.
    - Else pointer+1 -> HI.
  - In HI/LO, 8'h55 is plain data, not a resync.
  - No timeout: an incomplete load stays waiting indefinitely.
- Simultaneous read and write to the same address: read-first. Output shows old colour; new colour appears on the next access.
- Reset mid-load: FSM -> IDLE, pointer=0. Tiles already written keep their values; the partial R latch is discarded.
- wr_valid with wr_ready=0 (in reset): byte not consumed.

Optional Feature:
- Macro: TILE_FRAMEBUFFER_DOUBLE_BUFFER_EN.
- Defined:
  - Two RAM banks; display reads the front bank and the load FSM writes the back bank.
  - load_done sets swap_pending.
  - On the first cycle with h_count==0 && v_count==0 while swap_pending, the front/back select toggles and swap_pending clears.
  - Reset: front=bank0, swap_pending=0.
  - A new load may start before the swap; it overwrites the back bank, and the swap still occurs at the next frame start.
- Undefined: single bank; writes are visible on the next read of that tile, so mid-frame tearing is permitted.

Decomposition:
- Package vga_tile_pkg:
  - COLOUR_W=12
  - SYNC_BYTE=8'h55
  - rgb_t typedef (struct R,G,B 4 bits each)
  - load_state_t enum {IDLE,HI,LO}
- Sub-module tile_ram:
  - Simple dual-port, one write port, one registered read-first read port.
  - Parameters DEPTH and WIDTH; instantiated once, or twice under double buffering.

Test Plan:
- Reset, then video_on=1, h=0, v=0 -> rgb_colour=12'h000 for all cycles (RAM initialised to zero); wr_ready=1 one cycle after rst_n rises.
- Send 55, then 300 pairs (0x0F,0x00), i.e. tile0=12'hF00, all others 12'h000 -> load_done pulses exactly once after the 601st byte; at h=31, v=31 output 12'hF00 two cycles later, at h=32, v=0 output 12'h000.
- Load tile 19 = 12'h0FF; sweep h=608..639, v=0 -> 12'h0FF; at h=640 (col 20 out of range) with video_on forced 1 -> 12'h000; video_on=0 inside a tile -> 12'h000 with 2-cycle alignment.
- Send 55, 0A, BC then assert rst_n=0 for 1 cycle, then send 55 and a full load -> tile0 equals the new data, the partial first load has no effect beyond tile0, load_done fires once.
- Leading garbage bytes 00, FF, 12 before 55 are ignored; 55 used as a data byte in HI/LO stores 12'h555 correctly.
- DOUBLE_BUFFER_EN: complete a load mid-frame -> output unchanged until the h=0, v=0 cycle; new colours appear from that frame onward; without the macro, colours change immediately after load_done.
